// File: rtl/pe_buffer_reader_pkg.sv
// Shared types and helpers for the PE operand buffer read side.
package pe_buf_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } rd_state_t;

   // Reads outstanding plus words queued may never exceed this.
   localparam int RD_FIFO_DEPTH = 2;

   function automatic int unsigned wrap_inc(input int unsigned addr, input int unsigned depth);
      return (addr + 1 >= depth) ? 0 : addr + 1;
   endfunction

endpackage

// File: rtl/pe_buffer_reader_if.sv
// Control, buffer read port and output stream of the PE buffer reader.
interface pe_buffer_reader_if #(
   parameter int DATA_NUM   = 8,
   parameter int DATA_WIDTH = 16
);
   localparam int DEPTH      = 2 * DATA_NUM;
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int LEN_WIDTH  = $clog2(DEPTH + 1);

   logic                  start;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [LEN_WIDTH-1:0]  len;
   logic                  busy;
   logic                  done;
   logic                  mem_read_en;
   logic [ADDR_WIDTH-1:0] mem_read_addr;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_last;

   modport master (
      input  start, base_addr, len, mem_rdata, out_ready,
      output busy, done, mem_read_en, mem_read_addr, out_valid, out_data, out_last
   );

   modport slave (
      output start, base_addr, len, mem_rdata, out_ready,
      input  busy, done, mem_read_en, mem_read_addr, out_valid, out_data, out_last
   );
endinterface

// File: rtl/pe_buffer_reader_skid_fifo.sv
// Two-entry FIFO holding returned buffer words ({last, data}) until the PE accepts them.
module pe_skid_fifo
   import pe_buf_pkg::*;
#(
   parameter int W = 17
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] push_data,
   input  logic         pop,
   output logic [W-1:0] head,
   output logic [1:0]   count
);

   logic [W-1:0] slot_q [RD_FIFO_DEPTH];
   logic [W-1:0] slot_d [RD_FIFO_DEPTH];
   logic         wr_q, wr_d;
   logic         rd_q, rd_d;
   logic [1:0]   cnt_q, cnt_d;

   always_comb begin
      slot_d = slot_q;
      wr_d   = wr_q;
      rd_d   = rd_q;
      if (push) begin
         slot_d[wr_q] = push_data;
         wr_d         = ~wr_q;
      end
      if (pop) begin
         rd_d = ~rd_q;
      end
      cnt_d = cnt_q + 2'(push) - 2'(pop);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < RD_FIFO_DEPTH; i++) slot_q[i] <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         cnt_q <= '0;
      end else begin
         slot_q <= slot_d;
         wr_q   <= wr_d;
         rd_q   <= rd_d;
         cnt_q  <= cnt_d;
      end
   end

   // The head slot is never the push target while occupied, so it stays stable under stall.
   assign head  = slot_q[rd_q];
   assign count = cnt_q;

endmodule

// File: rtl/pe_buffer_reader.sv
// Read-side sequencer: bursts sequential buffer reads and returns them as a backpressured stream.
//
//  state | meaning
//  IDLE  | waiting for start; len==0 start only pulses done
//  RUN   | issuing reads while credit allows
//  DRAIN | all reads issued, waiting for the last word to be accepted
module pe_buffer_reader
   import pe_buf_pkg::*;
#(
   parameter int DATA_NUM   = 8,
   parameter int DATA_WIDTH = 16
) (
   input logic                 clk,
   input logic                 rst,
   pe_buffer_reader_if.master  bus
);

   localparam int DEPTH      = 2 * DATA_NUM;
   localparam int ADDR_WIDTH = $clog2(DEPTH);
   localparam int LEN_WIDTH  = $clog2(DEPTH + 1);

   rd_state_t             state_q, state_d;
   logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
   logic [LEN_WIDTH-1:0]  issued_q, issued_d;
   logic [LEN_WIDTH-1:0]  len_q, len_d;
   logic                  inflight_q, inflight_d;
   logic                  inflight_last_q, inflight_last_d;
   logic                  done_q, done_d;

   logic [LEN_WIDTH-1:0]  len_eff;
   logic [1:0]            fifo_count;
   logic [DATA_WIDTH:0]   fifo_head;
   logic                  out_valid;
   logic                  pop;
   logic                  issue_ok;
   logic                  issue_last;
   logic                  issue;

   assign len_eff    = (bus.len > LEN_WIDTH'(DEPTH)) ? LEN_WIDTH'(DEPTH) : bus.len;
   assign out_valid  = (fifo_count != 2'd0);
   assign pop        = out_valid & bus.out_ready;
   // A word popped this cycle frees its slot in time for a read issued now.
   assign issue_ok   = ({1'b0, fifo_count} + {2'b00, inflight_q}) < (3'(RD_FIFO_DEPTH) + {2'b00, pop});
   assign issue_last = (issued_q == len_q - LEN_WIDTH'(1));

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      issued_d = issued_q;
      len_d    = len_q;
      done_d   = 1'b0;
      issue    = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (bus.len == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = RUN;
                  ptr_d    = bus.base_addr;
                  issued_d = '0;
                  len_d    = len_eff;
               end
            end
         end
         RUN: begin
            if (issue_ok) begin
               issue    = 1'b1;
               ptr_d    = ADDR_WIDTH'(wrap_inc(32'(ptr_q), DEPTH));
               issued_d = issued_q + LEN_WIDTH'(1);
               if (issue_last) state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (pop && fifo_head[DATA_WIDTH]) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      inflight_d      = issue;
      inflight_last_d = issue & issue_last;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= IDLE;
         ptr_q           <= '0;
         issued_q        <= '0;
         len_q           <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
         done_q          <= 1'b0;
      end else begin
         state_q         <= state_d;
         ptr_q           <= ptr_d;
         issued_q        <= issued_d;
         len_q           <= len_d;
         inflight_q      <= inflight_d;
         inflight_last_q <= inflight_last_d;
         done_q          <= done_d;
      end
   end

   pe_skid_fifo #(
      .W (DATA_WIDTH + 1)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (inflight_q),
      .push_data ({inflight_last_q, bus.mem_rdata}),
      .pop       (pop),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign bus.busy          = (state_q != IDLE);
   assign bus.done          = done_q;
   assign bus.mem_read_en   = issue;
   assign bus.mem_read_addr = ptr_q;
   assign bus.out_valid     = out_valid;
   assign bus.out_data      = fifo_head[DATA_WIDTH-1:0];
   assign bus.out_last      = out_valid & fifo_head[DATA_WIDTH];

endmodule

// File: tb/tb_pe_buffer_reader.sv
// Self-checking bench for pe_buffer_reader with a buffer model and stream scoreboard.
module tb_pe_buffer_reader;

   localparam int DN    = 8;
   localparam int DW    = 16;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } word_t;

   typedef struct {
      int base;
      int len;
      int mode;
      int inject;
      int exp_words;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   pe_buffer_reader_if #(.DATA_NUM(DN), .DATA_WIDTH(DW)) bus();

   pe_buffer_reader #(.DATA_NUM(DN), .DATA_WIDTH(DW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [DW-1:0] mem [DEPTH];
   int    total = 0;
   int    bad   = 0;
   int    cyc   = 0;
   word_t exp_q[$];
   int    addr_q[$];
   int    rdy_mode = 0;
   int    rdy_idx  = 0;
   int    first_valid_cyc, first_busy_cyc, last_hs_cyc, done_cyc, done_cnt, popped, issued;
   logic  stall_prev = 1'b0;
   word_t prev_w;
   vec_t  vecs[7];

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Buffer model: registered read port, garbage when no read was issued.
   always @(posedge clk)
      bus.mem_rdata <= bus.mem_read_en ? mem[bus.mem_read_addr] : DW'($urandom);

   initial begin
      logic [5:0] pat;
      pat = 6'b101001;
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       begin bus.out_ready = pat[rdy_idx % 6]; rdy_idx++; end
            2:       bus.out_ready = 1'($urandom_range(0, 1));
            default: bus.out_ready = 1'b0;
         endcase
      end
   end

   always @(negedge clk) begin
      word_t w;
      if (!rst) begin
         if (stall_prev) begin
            check("stall_valid", bus.out_valid, 1);
            check("stall_data", bus.out_data, prev_w.data);
            check("stall_last", bus.out_last, prev_w.last);
         end
         if (bus.mem_read_en) begin
            issued++;
            if (addr_q.size() == 0) check("read_addr_q", addr_q.size(), 1);
            else                    check("read_addr", bus.mem_read_addr, addr_q.pop_front());
         end
         if (bus.busy && first_busy_cyc < 0) first_busy_cyc = cyc;
         if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            popped++;
            if (exp_q.size() == 0) check("word_q", exp_q.size(), 1);
            else begin
               w = exp_q.pop_front();
               check("out_data", bus.out_data, w.data);
               check("out_last", bus.out_last, w.last);
            end
            if (bus.out_last) begin
               last_hs_cyc = cyc;
               check("busy_at_last", bus.busy, 1);
            end
         end
         if (bus.mem_read_en) check("outstanding", int'((issued - popped) <= 2), 1);
         if (bus.done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         stall_prev = bus.out_valid && !bus.out_ready;
         prev_w     = {bus.out_last, bus.out_data};
      end else begin
         stall_prev = 1'b0;
      end
   end

   task automatic clear_tracking();
      exp_q.delete();
      addr_q.delete();
      first_valid_cyc = -1;
      first_busy_cyc  = -1;
      last_hs_cyc     = -1;
      done_cyc        = -1;
      done_cnt        = 0;
      popped          = 0;
      issued          = 0;
   endtask

   task automatic push_expected(input int base, input int len);
      int    eff;
      int    a;
      word_t w;
      eff = (len > DEPTH) ? DEPTH : len;
      for (int i = 0; i < eff; i++) begin
         a      = (base + i) % DEPTH;
         w.data = DW'(32'hA000 + a);
         w.last = (i == eff - 1);
         addr_q.push_back(a);
         exp_q.push_back(w);
      end
   endtask

   task automatic run_burst(input int base, input int len, input int mode,
                            input int inject, input int exp_words);
      int s;
      clear_tracking();
      push_expected(base, len);
      rdy_mode = mode;
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.base_addr = 4'(base);
      bus.len       = 5'(len);
      @(posedge clk); #1;
      bus.start = 1'b0;
      s = cyc;
      for (int i = 0; i < 400 && done_cnt == 0; i++) begin
         if (i == inject) begin
            bus.start     = 1'b1;
            bus.base_addr = 4'd8;
            bus.len       = 5'd4;
         end
         @(posedge clk); #1;
         bus.start = 1'b0;
      end
      if (done_cnt == 0) check("done_timeout", done_cnt, 1);
      repeat (3) begin @(posedge clk); #1; end
      check("words", popped, exp_words);
      check("exp_left", exp_q.size(), 0);
      check("addr_left", addr_q.size(), 0);
      check("done_pulses", done_cnt, 1);
      check("busy_idle", bus.busy, 0);
      if (exp_words > 0) begin
         check("valid_latency", first_valid_cyc - s, 2);
         check("busy_start", first_busy_cyc - s, 0);
         check("done_after_last", done_cyc - last_hs_cyc, 1);
      end else begin
         check("len0_done", done_cyc - s, 0);
         check("len0_reads", issued, 0);
         check("len0_busy", first_busy_cyc, -1);
         check("len0_valid", first_valid_cyc, -1);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"}, bus.busy, 0);
      check({tag, "_done"}, bus.done, 0);
      check({tag, "_rd_en"}, bus.mem_read_en, 0);
      check({tag, "_rd_addr"}, bus.mem_read_addr, 0);
      check({tag, "_valid"}, bus.out_valid, 0);
      check({tag, "_last"}, bus.out_last, 0);
      check({tag, "_data"}, bus.out_data, 0);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(32'hA000 + i);
      vecs[0] = '{base: 0,  len: 8,  mode: 0, inject: -1, exp_words: 8};
      vecs[1] = '{base: 14, len: 4,  mode: 0, inject: -1, exp_words: 4};
      vecs[2] = '{base: 0,  len: 8,  mode: 1, inject: -1, exp_words: 8};
      vecs[3] = '{base: 0,  len: 20, mode: 0, inject: -1, exp_words: 16};
      vecs[4] = '{base: 3,  len: 8,  mode: 0, inject: 2,  exp_words: 8};
      vecs[5] = '{base: 15, len: 16, mode: 2, inject: -1, exp_words: 16};
      vecs[6] = '{base: 5,  len: 1,  mode: 1, inject: -1, exp_words: 1};

      bus.start     = 1'b0;
      bus.base_addr = '0;
      bus.len       = '0;
      bus.out_ready = 1'b1;
      clear_tracking();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_all_zero("reset");
      rst = 1'b0;

      for (int v = 0; v < 7; v++)
         run_burst(vecs[v].base, vecs[v].len, vecs[v].mode, vecs[v].inject, vecs[v].exp_words);

      run_burst(7, 0, 0, -1, 0);

      // Reset in the middle of a stalled burst with the FIFO full.
      clear_tracking();
      push_expected(0, 8);
      rdy_mode = 3;
      @(posedge clk); #1;
      bus.start     = 1'b1;
      bus.base_addr = 4'd0;
      bus.len       = 5'd8;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (6) begin @(posedge clk); #1; end
      check("stalled_valid", bus.out_valid, 1);
      check("stalled_reads", issued, 2);
      check("stalled_busy", bus.busy, 1);
      #2;
      rst = 1'b1;
      #1;
      check_all_zero("midrst");
      repeat (2) @(posedge clk);
      #1;
      clear_tracking();
      rdy_mode = 0;
      rst = 1'b0;
      repeat (5) begin @(posedge clk); #1; end
      check("rst_no_done", done_cnt, 0);
      check("rst_no_reads", issued, 0);
      check("rst_no_valid", first_valid_cyc, -1);

      run_burst(0, 8, 0, -1, 8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
